iobus_uart_tx: RTL

IOBUS_UART_TX -- requirements
Module: iobus_uart_tx

---
 rtl/otter_mmio_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 33 +++
 rtl/iobus_uart_tx.sv | 108 ++++++++++
 3 files changed

// File: rtl/otter_mmio_pkg.sv
// otter_mmio_pkg: MMIO addresses, UART status bit positions and TX FSM states.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package otter_mmio_pkg;
  localparam logic [31:0] UART_DATA_AD = 32'h1110_0000;
  localparam logic [31:0] UART_STAT_AD = 32'h1114_0000;
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two FIFO with an extra pointer bit separating full from empty.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end
  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
endmodule

// File: rtl/iobus_uart_tx.sv
// iobus_uart_tx: MMIO-fed buffered UART transmitter (8N1, or 8E1 with UART_TX_PARITY_EN).
module iobus_uart_tx
  import otter_mmio_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX
);
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  uart_tx_state_t state;
  logic [15:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, fifo_dout;
  logic full, empty, ovf, busy;
  logic data_wr, stat_wr, fifo_push, fifo_pop;
  logic [31:0] stat;
  logic unused_bits;
`ifdef UART_TX_PARITY_EN
  logic par;
`endif
  assign data_wr     = IOBUS_WR && IOBUS_ADDR == UART_DATA_AD;
  assign stat_wr     = IOBUS_WR && IOBUS_ADDR == UART_STAT_AD;
  assign busy        = state != IDLE;
  assign fifo_pop    = !empty && (state == IDLE || (state == STOP && baud_cnt == '0));
  assign fifo_push   = data_wr && (!full || fifo_pop);
  assign unused_bits = ^IOBUS_OUT[31:8];
  uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK), .rst_n(RST_N), .push(fifo_push), .pop(fifo_pop),
    .din(IOBUS_OUT[7:0]), .dout(fifo_dout), .full(full), .empty(empty)
  );
  always_comb begin
    stat = '0;
    stat[STAT_FULL]  = full;
    stat[STAT_EMPTY] = empty;
    stat[STAT_BUSY]  = busy;
    stat[STAT_OVF]   = ovf;
    IOBUS_IN = IOBUS_ADDR == UART_STAT_AD ? stat : '0;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ovf <= 1'b0;
    else ovf <= (data_wr && full && !fifo_pop) || (ovf && !(stat_wr && IOBUS_OUT[3]));
  end
  // A pop always starts a frame, whether from IDLE or straight out of an expiring STOP.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      TX       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else if (fifo_pop) begin
      state    <= START;
      TX       <= 1'b0;
      baud_cnt <= BAUD_LAST;
      shreg    <= fifo_dout;
`ifdef UART_TX_PARITY_EN
      par      <= ^fifo_dout;
`endif
    end else if (busy) begin
      if (baud_cnt != '0) baud_cnt <= baud_cnt - 16'd1;
      else begin
        baud_cnt <= BAUD_LAST;
        case (state)
          START: begin
            state   <= DATA;
            TX      <= shreg[0];
            bit_cnt <= '0;
          end
          DATA: begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              TX    <= par;
`else
              state <= STOP;
              TX    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= shreg >> 1;
              TX      <= shreg[1];
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state <= STOP;
            TX    <= 1'b1;
          end
`endif
          default: begin
            state <= IDLE;
            TX    <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule
